fetch_stage: RTL and testbench

Instruction fetch stage of the core pipeline; the producer side of the decode stage's submit/ready handshake. Maintains the PC and issues word fetches to instruction memory. Hands one 32-bit instruction per transfer to decode as a 16-bit low word plus a 16-bit immediate, together with a static jump prediction. Redirects the PC on pipeline flush from execute.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_branch_predict.sv | 41 ++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Brief    : Shared fetch-stage constants, opcode values and state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int I_SIZE = 32;
  localparam int PC_W   = 16;

  localparam logic [6:0] OPC_JMP = 7'h0E;
  localparam logic [6:0] OPC_JAL = 7'h0F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_HOLD  = ST_HOLD,
    S_DROP  = ST_DROP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_branch_predict.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict
// Brief    : Static jump predictor; only elaborated when BRANCH_PRED_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef BRANCH_PRED_EN
module branch_predict
  import fetch_stage_pkg::*;
(
  input  logic [I_SIZE-1:0] i_instr,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_taken,
  output logic [PC_W-1:0]   o_next_pc
);

  logic [6:0]      w_opc;
  logic [3:0]      w_cond;
  logic [PC_W-1:0] w_imm;
  logic            w_unused;

  assign w_opc    = i_instr[6:0];
  assign w_cond   = i_instr[10:7];
  assign w_imm    = i_instr[31:16];
  assign w_unused = ^i_instr[15:11];

  // Conditional jumps are guessed taken only when they point backwards (loops).
  always_comb begin
    o_taken = 1'b0;
    if (w_opc == OPC_JAL) begin
      o_taken = 1'b1;
    end else if (w_opc == OPC_JMP) begin
      o_taken = (w_cond == 4'd0) || (w_imm < i_pc);
    end
  end

  assign o_next_pc = o_taken ? w_imm : i_pc + 16'd1;

endmodule
`endif
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch with decode handshake, flush redirect and
//            optional static jump prediction (macro BRANCH_PRED_EN).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  input  logic        i_next_ready,
  output logic        o_submit,
  output logic [15:0] o_instr_l,
  output logic [15:0] o_imm_pass,
  output logic        o_jmp_pred_pass,
  input  logic        i_flush,
  input  logic [15:0] i_flush_pc
);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_addr;
  logic [I_SIZE-1:0] r_buf;
  logic              r_submit;
  logic [15:0]       r_instr_l;
  logic [15:0]       r_imm;
  logic              r_pred;

  logic [I_SIZE-1:0] w_instr;
  logic              w_taken;
  logic [PC_W-1:0]   w_next_pc;

  assign w_instr = (r_state == S_HOLD) ? r_buf : i_mem_data;

`ifdef BRANCH_PRED_EN
  branch_predict u_branch_predict (
    .i_instr   (w_instr),
    .i_pc      (r_pc),
    .o_taken   (w_taken),
    .o_next_pc (w_next_pc)
  );
`else
  assign w_taken   = 1'b0;
  assign w_next_pc = r_pc + 16'd1;
`endif

  // r_addr normally tracks r_pc; it diverges only in S_DROP, where the
  // abandoned request must keep its address until memory acknowledges it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_buf     <= '0;
      r_submit  <= 1'b0;
      r_instr_l <= 16'h0000;
      r_imm     <= 16'h0000;
      r_pred    <= 1'b0;
    end else begin
      r_submit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_flush) begin
            r_pc <= i_flush_pc;
            if (i_mem_ack) begin
              r_addr <= i_flush_pc;
            end else begin
              r_state <= S_DROP;
            end
          end else if (i_mem_ack) begin
            if (i_next_ready) begin
              r_submit  <= 1'b1;
              r_instr_l <= w_instr[15:0];
              r_imm     <= w_instr[31:16];
              r_pred    <= w_taken;
              r_pc      <= w_next_pc;
              r_addr    <= w_next_pc;
            end else begin
              r_buf   <= i_mem_data;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_flush) begin
            r_pc    <= i_flush_pc;
            r_addr  <= i_flush_pc;
            r_state <= S_FETCH;
          end else if (i_next_ready) begin
            r_submit  <= 1'b1;
            r_instr_l <= w_instr[15:0];
            r_imm     <= w_instr[31:16];
            r_pred    <= w_taken;
            r_pc      <= w_next_pc;
            r_addr    <= w_next_pc;
            r_state   <= S_FETCH;
          end
        end
        S_DROP: begin
          // A flush here re-targets the PC; a completing ack re-issues at it,
          // still under drop since the state is retained.
          if (i_flush) begin
            r_pc <= i_flush_pc;
            if (i_mem_ack) begin
              r_addr <= i_flush_pc;
            end
          end else if (i_mem_ack) begin
            r_addr  <= r_pc;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req       = (r_state == S_FETCH) || (r_state == S_DROP);
  assign o_mem_addr      = r_addr;
  assign o_submit        = r_submit;
  assign o_instr_l       = r_instr_l;
  assign o_imm_pass      = r_imm;
  assign o_jmp_pred_pass = r_pred;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: directed scenarios plus a
//            randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0;
  logic        ready = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] fpc = 16'h0000;
  logic [31:0] mdata = 32'h0;

  logic        req;
  logic [15:0] addr;
  logic        sub;
  logic [15:0] instr_l;
  logic [15:0] imm;
  logic        pred;

  fetch_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_mem_req       (req),
    .o_mem_addr      (addr),
    .i_mem_ack       (ack),
    .i_mem_data      (mdata),
    .i_next_ready    (ready),
    .o_submit        (sub),
    .o_instr_l       (instr_l),
    .o_imm_pass      (imm),
    .o_jmp_pred_pass (pred),
    .i_flush         (flush),
    .i_flush_pc      (fpc)
  );

  always #5 clk = ~clk;

`ifdef BRANCH_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Instruction memory image; unknown words are NOPs until random mode fills them.
  logic [31:0] img [logic [15:0]];
  bit          rand_img = 1'b0;

  function automatic logic [31:0] gen_instr();
    logic [15:0] im;
    logic [4:0]  hi;
    im = 16'($urandom);
    hi = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       return {im, hi, 4'($urandom), 7'h0F};
      1:       return {im, hi, 4'd0, 7'h0E};
      2:       return {im, hi, 4'($urandom_range(1, 15)), 7'h0E};
      default: return {im, hi, 4'($urandom), 7'($urandom_range(16, 127))};
    endcase
  endfunction

  function automatic logic [31:0] img_word(logic [15:0] a);
    if (!img.exists(a)) begin
      if (!rand_img) return 32'h0;
      img[a] = gen_instr();
    end
    return img[a];
  endfunction

  // Reference model: what has been fetched but not yet handed over, and
  // whether the outstanding request is one whose data is unwanted.
  bit          m_started;
  bit          m_drop;
  logic [31:0] m_held [$];
  logic [15:0] m_pc, m_addr, m_il, m_imm;
  bit          m_sub, m_pred;

  function automatic bit exp_taken(logic [31:0] w, logic [15:0] pc);
    if (!PRED) return 1'b0;
    if (w[6:0] == 7'h0F) return 1'b1;
    if (w[6:0] == 7'h0E) return (w[10:7] == 4'd0) || (w[31:16] < pc);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_drop    = 1'b0;
    m_held.delete();
    m_pc      = 16'h0000;
    m_addr    = 16'h0000;
    m_il      = 16'h0000;
    m_imm     = 16'h0000;
    m_sub     = 1'b0;
    m_pred    = 1'b0;
  endtask

  task automatic model_step();
    bit          asking, done, have;
    logic [31:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    asking = m_started && (m_held.size() == 0);
    done   = asking && ack;
    m_sub  = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    if (flush) begin
      m_pc = fpc;
      m_held.delete();
      if (asking && !done) m_drop = 1'b1;
      else begin
        m_addr = fpc;
        if (!(m_drop && done)) m_drop = 1'b0;
      end
      return;
    end
    if (done && m_drop) begin
      m_drop = 1'b0;
      m_addr = m_pc;
      return;
    end
    have = 1'b0;
    w    = mdata;
    if (m_held.size() != 0) begin
      have = 1'b1;
      w    = m_held[0];
    end else if (done) begin
      have = 1'b1;
    end
    if (have) begin
      if (ready) begin
        m_sub  = 1'b1;
        m_il   = w[15:0];
        m_imm  = w[31:16];
        m_pred = exp_taken(w, m_pc);
        m_pc   = m_pred ? w[31:16] : m_pc + 16'd1;
        m_addr = m_pc;
        m_held.delete();
      end else if (m_held.size() == 0) begin
        m_held.push_back(w);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("req",     {31'b0, req},  {31'b0, (m_started && m_held.size() == 0)});
    chk("addr",    {16'b0, addr}, {16'b0, m_addr});
    chk("submit",  {31'b0, sub},  {31'b0, m_sub});
    chk("instr_l", {16'b0, instr_l}, {16'b0, m_il});
    chk("imm",     {16'b0, imm},  {16'b0, m_imm});
    chk("pred",    {31'b0, pred}, {31'b0, m_pred});
  endtask

  // One clock: advance the model with the inputs applied, then compare.
  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
    mdata = img_word(addr);
  endtask

  initial begin
    model_reset();
    img[16'h0000] = 32'h0005_0207;
    img[16'h0002] = 32'h1234_5601;
    img[16'h0008] = 32'h0040_000F;
    img[16'h0010] = 32'h0002_008E;
    img[16'h0100] = 32'h0000_0A01;
    img[16'hFFFF] = 32'h0000_0001;

    cycle();
    cycle();
    chk("rst_req",  {31'b0, req}, 32'd0);
    chk("rst_addr", {16'b0, addr}, 32'h0000);
    chk("rst_sub",  {31'b0, sub}, 32'd0);
    chk("rst_instr", {16'b0, instr_l}, 32'h0000);

    // zero-wait memory, decode always ready
    rst_n = 1'b1; ack = 1'b1; ready = 1'b1;
    cycle();
    chk("zw_addr0", {16'b0, addr}, 32'h0000);
    chk("zw_req",   {31'b0, req}, 32'd1);
    cycle();
    chk("zw_sub",   {31'b0, sub}, 32'd1);
    chk("zw_instr", {16'b0, instr_l}, 32'h0207);
    chk("zw_imm",   {16'b0, imm}, 32'h0005);
    chk("zw_addr1", {16'b0, addr}, 32'h0001);
    cycle();
    chk("zw_addr2", {16'b0, addr}, 32'h0002);

    // decode stalls three cycles
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_req", {31'b0, req}, 32'd0);
      chk("hold_sub", {31'b0, sub}, 32'd0);
    end
    ready = 1'b1;
    cycle();
    chk("hold_rel_sub",   {31'b0, sub}, 32'd1);
    chk("hold_rel_instr", {16'b0, instr_l}, 32'h5601);
    chk("hold_rel_imm",   {16'b0, imm}, 32'h1234);
    chk("hold_rel_addr",  {16'b0, addr}, 32'h0003);

    // flush together with ack and ready, then JAL at 8
    flush = 1'b1; fpc = 16'h0008;
    cycle();
    chk("fl_ack_sub",  {31'b0, sub}, 32'd0);
    chk("fl_ack_addr", {16'b0, addr}, 32'h0008);
    flush = 1'b0;
    cycle();
    chk("jal_instr", {16'b0, instr_l}, 32'h000F);
    chk("jal_pred",  {31'b0, pred}, {31'b0, PRED});
    chk("jal_addr",  {16'b0, addr}, PRED ? 32'h0040 : 32'h0009);

    // conditional backward then forward jump at 0x10
    flush = 1'b1; fpc = 16'h0010;
    cycle();
    flush = 1'b0;
    cycle();
    chk("jmpb_pred", {31'b0, pred}, {31'b0, PRED});
    chk("jmpb_addr", {16'b0, addr}, PRED ? 32'h0002 : 32'h0011);
    img[16'h0010] = 32'h0020_008E;
    flush = 1'b1; fpc = 16'h0010;
    cycle();
    flush = 1'b0;
    cycle();
    chk("jmpf_sub",  {31'b0, sub}, 32'd1);
    chk("jmpf_pred", {31'b0, pred}, 32'd0);
    chk("jmpf_addr", {16'b0, addr}, 32'h0011);

    // flush with the ack delayed two cycles
    ack = 1'b0; flush = 1'b1; fpc = 16'h0100;
    cycle();
    chk("drop_addr_a", {16'b0, addr}, 32'h0011);
    chk("drop_req",    {31'b0, req}, 32'd1);
    flush = 1'b0;
    cycle();
    chk("drop_addr_b", {16'b0, addr}, 32'h0011);
    ack = 1'b1;
    cycle();
    chk("drop_sub",  {31'b0, sub}, 32'd0);
    chk("drop_addr", {16'b0, addr}, 32'h0100);
    cycle();
    chk("drop_next_instr", {16'b0, instr_l}, 32'h0A01);

    // PC wrap
    flush = 1'b1; fpc = 16'hFFFF;
    cycle();
    flush = 1'b0;
    cycle();
    chk("wrap_sub",  {31'b0, sub}, 32'd1);
    chk("wrap_addr", {16'b0, addr}, 32'h0000);

    // reset while a request is outstanding; ack after release is ignored
    ack = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; ack = 1'b1;
    cycle();
    chk("rstmid_sub", {31'b0, sub}, 32'd0);
    chk("rstmid_req", {31'b0, req}, 32'd1);
    cycle();
    chk("rstmid_instr", {16'b0, instr_l}, 32'h0207);

    // randomized traffic
    rand_img = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      int ack_pct, rdy_pct;
      ack_pct = (blk % 4 == 0) ? 100 : int'($urandom_range(20, 90));
      rdy_pct = int'($urandom_range(30, 100));
      for (int i = 0; i < 500; i++) begin
        ack   = ($urandom_range(0, 99) < ack_pct);
        ready = ($urandom_range(0, 99) < rdy_pct);
        flush = ($urandom_range(0, 99) < 5);
        fpc   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                            : 16'($urandom);
        rst_n = ($urandom_range(0, 599) != 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
